// File: rtl/imem_loader_pkg.sv
// Shared constants for the core and the boot-time IMEM loader.
// Loader state encoding, header size and default capacity/timeout live here.
package imem_loader_pkg;

  localparam int XLEN = 32;
  localparam int WORD_BYTES = XLEN / 8;

  localparam int HDR_BYTES = 4;
  localparam int DEF_MEM_BYTES = 4096;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LEN   = 3'd1,
    LD_DATA  = 3'd2,
    LD_FLUSH = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } ld_state_t;

  // Little-endian byte insert: lane k occupies bits [8k+7:8k].
  function automatic logic [XLEN-1:0] put_lane(input logic [XLEN-1:0] w,
                                               input logic [1:0]      lane,
                                               input logic [7:0]      b);
    logic [XLEN-1:0] r;
    r = w;
    r[8*int'(lane) +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian words; a tail byte emits a
// zero-filled partial word. Emitted words are registered, one-cycle word_valid.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  input  logic            byte_last,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  logic [XLEN-1:0] acc;
  logic [1:0]      lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      lane       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        acc  <= '0;
        lane <= '0;
      end else if (byte_valid) begin
        if (lane == 2'd3 || byte_last) begin
          // acc is zeroed after every emit, so unfilled upper lanes read 0
          word       <= put_lane(acc, lane, byte_data);
          word_valid <= 1'b1;
          acc        <= '0;
          lane       <= '0;
        end else begin
          acc  <= put_lane(acc, lane, byte_data);
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream in, word writes to IMEM port A out.
// Holds the core in reset until the final word has been committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES      = DEF_MEM_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_di,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output ld_state_t   dbg_state
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: a byte moves on rx_valid && rx_ready; rx_ready depends only on
  // the current state (high in LEN/DATA), so it never depends on rx_valid.

  ld_state_t       state, state_nx;
  logic [IW-1:0]   idle_cnt;
  logic [1:0]      hdr_cnt;
  logic [31:0]     len_acc;
  logic [31:0]     hdr_len;
  logic [31:0]     remaining;
  logic [29:0]     word_index;

  logic            loading;
  logic            accept;
  logic            hdr_last;
  logic            len_bad;
  logic            data_last;
  logic            timeout;
  logic            restart;
  logic            pk_clear;
  logic            pk_word_valid;
  logic [XLEN-1:0] pk_word;

  assign loading   = (state == LD_LEN) || (state == LD_DATA);
  assign rx_ready  = loading;
  assign accept    = rx_valid && loading;
  assign hdr_len   = put_lane(len_acc, hdr_cnt, rx_data);
  assign hdr_last  = (state == LD_LEN) && accept && (hdr_cnt == 2'(HDR_BYTES - 1));
  assign len_bad   = (hdr_len == 32'd0) || (hdr_len > 32'(MEM_BYTES));
  assign data_last = (state == LD_DATA) && accept && (remaining == 32'd1);
  // An accepted byte in the expiry cycle wins over the timeout.
  assign timeout   = loading && !accept && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
  assign restart   = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR));
  assign pk_clear  = restart || timeout;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_valid ((state == LD_DATA) && accept),
    .byte_data  (rx_data),
    .byte_last  (data_last),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_nx = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERR: if (start) state_nx = LD_LEN;
      LD_LEN: begin
        if (timeout)       state_nx = LD_ERR;
        else if (hdr_last) state_nx = len_bad ? LD_ERR : LD_DATA;
      end
      LD_DATA: begin
        if (timeout)        state_nx = LD_ERR;
        else if (data_last) state_nx = LD_FLUSH;
      end
      LD_FLUSH: state_nx = LD_DONE;
      default:  state_nx = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LD_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
      idle_cnt   <= '0;
      hdr_cnt    <= '0;
      len_acc    <= '0;
      remaining  <= '0;
      word_index <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx == LD_LEN) || (state_nx == LD_DATA) || (state_nx == LD_FLUSH);
      done       <= (state_nx == LD_DONE);
      err        <= (state_nx == LD_ERR);
      core_rst_n <= (state_nx == LD_DONE);

      if (restart) begin
        idle_cnt   <= '0;
        hdr_cnt    <= '0;
        len_acc    <= '0;
        remaining  <= '0;
        word_index <= '0;
      end else begin
        if (!loading || accept || timeout) idle_cnt <= '0;
        else                               idle_cnt <= idle_cnt + IW'(1);

        if ((state == LD_LEN) && accept) begin
          len_acc <= hdr_len;
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_last && !len_bad) begin
            remaining  <= hdr_len;
            word_index <= '0;
          end
        end

        if ((state == LD_DATA) && accept) remaining <= remaining - 32'd1;

        // Address advances after each committed write, so the write uses the old index.
        if (pk_word_valid) word_index <= word_index + 30'd1;
      end
    end
  end

  assign mem_we    = {4{pk_word_valid}};
  assign mem_addr  = pk_word_valid ? {word_index, 2'b00} : 32'd0;
  assign mem_di    = pk_word_valid ? pk_word : 32'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole loads plus hand-built timeout,
// restart-ignore and async-reset sequences; writes checked against a queue.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MEMB = 4096;
  localparam int TMO  = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  ld_state_t   dbg_state;

  imem_loader #(.MEM_BYTES(MEMB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_di     (mem_di),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {we, addr, di}
  logic [67:0] exp_q[$];
  logic [67:0] mon_e;
  int checks = 0;
  int errors = 0;
  logic [7:0] pay_buf[4096];

  typedef struct {
    logic [31:0] n;
    logic [95:0] pay;
    bit          rnd;
    bit          exp_err;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_we !== 4'h0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=we %h addr %h di %h required=no write",
                   mem_we, mem_addr, mem_di);
        end else begin
          mon_e = exp_q.pop_front();
          check("mem_write", {mem_we, mem_addr, mem_di}, mon_e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = rx_ready;
      @(posedge clk);
    end
    #1;
    rx_valid = 1'b0;
    check("rx_accept", got, 1'b1);
  endtask

  task automatic send_header(input logic [31:0] n, input int gmax);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], $urandom_range(gmax, 0));
  endtask

  // Sends pay_buf[0..n-1]; byte slow_k gets gap slow_gap instead of a random one.
  task automatic send_payload(input int n, input int gmax, input int slow_k, input int slow_gap);
    logic [31:0] w;
    logic [31:0] addr;
    int lane;
    w = '0;
    addr = '0;
    lane = 0;
    for (int k = 0; k < n; k++) begin
      w[8*lane +: 8] = pay_buf[k];
      lane++;
      if (lane == 4 || k == n - 1) begin
        exp_q.push_back({4'hF, addr, w});
        addr = addr + 32'd4;
        w = '0;
        lane = 0;
      end
      send_byte(pay_buf[k], (k == slow_k) ? slow_gap : $urandom_range(gmax, 0));
    end
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    check({tag, "_flush"}, {busy, done, err, core_rst_n, mem_we}, {4'b1000, 4'hF});
    @(negedge clk);
    check({tag, "_done"}, {busy, done, err, core_rst_n, mem_we}, {4'b0101, 4'h0});
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    for (int k = 0; k < int'(v.n) && k < 4096; k++)
      pay_buf[k] = v.rnd ? 8'($urandom_range(255, 0)) : ((k < 12) ? v.pay[8*k +: 8] : 8'h00);
    pulse_start();
    check($sformatf("v%0d_start", idx), {busy, done, err, core_rst_n}, 4'b1000);
    send_header(v.n, 2);
    if (v.exp_err) begin
      check($sformatf("v%0d_hdr_err", idx), {busy, done, err, core_rst_n, rx_ready}, 5'b00100);
      repeat (3) tick();
      check($sformatf("v%0d_err_hold", idx), {err, core_rst_n}, 2'b10);
    end else begin
      send_payload(int'(v.n), (v.n > 100) ? 1 : 2, -1, 0);
      expect_done($sformatf("v%0d", idx));
    end
  endtask

  initial begin
    vecs[0] = '{n: 32'd8,    pay: 96'h0000_0000_0010_0093_0000_0013, rnd: 1'b0, exp_err: 1'b0};
    vecs[1] = '{n: 32'd5,    pay: 96'h0000_00AB_0403_0201,           rnd: 1'b0, exp_err: 1'b0};
    vecs[2] = '{n: 32'd0,    pay: 96'h0,                             rnd: 1'b0, exp_err: 1'b1};
    vecs[3] = '{n: 32'd4097, pay: 96'h0,                             rnd: 1'b0, exp_err: 1'b1};
    vecs[4] = '{n: 32'd4,    pay: 96'hEFBE_ADDE,                     rnd: 1'b0, exp_err: 1'b0};
    vecs[5] = '{n: 32'd1,    pay: 96'h5A,                            rnd: 1'b0, exp_err: 1'b0};
    vecs[6] = '{n: 32'd3,    pay: 96'h0,                             rnd: 1'b1, exp_err: 1'b0};
    vecs[7] = '{n: 32'd4096, pay: 96'h0,                             rnd: 1'b1, exp_err: 1'b0};
    vecs[8] = '{n: 32'd13,   pay: 96'h0,                             rnd: 1'b1, exp_err: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rx_ready, mem_we, mem_addr, mem_di, core_rst_n, busy, done, err},
          73'd0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {rx_ready, core_rst_n, busy, done, err}, 5'b0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Timeout: 3 payload bytes then silence; error lands after exactly 16 idle cycles.
    pulse_start();
    send_header(32'd8, 1);
    for (int k = 0; k < 3; k++) send_byte(8'(8'h30 + k), 0);
    repeat (16) @(negedge clk);
    check("tmo_not_yet", {busy, err}, 2'b10);
    @(negedge clk);
    check("tmo_err", {busy, done, err, core_rst_n, rx_ready}, 5'b00100);

    // Same case, but a byte arrives in the 16th idle cycle and cancels the timeout.
    for (int k = 0; k < 8; k++) pay_buf[k] = 8'($urandom_range(255, 0));
    pulse_start();
    send_header(32'd8, 1);
    send_payload(8, 0, 3, 15);
    expect_done("tmo_cancel");

    // start held high through DATA and FLUSH must be ignored.
    for (int k = 0; k < 8; k++) pay_buf[k] = 8'($urandom_range(255, 0));
    pulse_start();
    send_header(32'd8, 1);
    start = 1'b1;
    send_payload(8, 1, -1, 0);
    start = 1'b0;
    expect_done("start_ignored");

    // Async reset mid-DATA, then a clean 8-byte load.
    for (int k = 0; k < 8; k++) pay_buf[k] = 8'(8'hC0 + k);
    pulse_start();
    send_header(32'd8, 0);
    exp_q.push_back({4'hF, 32'd0, pay_buf[3], pay_buf[2], pay_buf[1], pay_buf[0]});
    for (int k = 0; k < 5; k++) send_byte(pay_buf[k], 0);
    check("mid_data_busy", {busy, rx_ready}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {rx_ready, mem_we, mem_addr, mem_di, core_rst_n, busy, done, err}, 73'd0);
    check("async_reset_queue", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of instruction memory, which the pipeline otherwise only reads.
- Accepts a length-prefixed byte stream from a UART RX front-end over a valid/ready handshake.
- Packs the bytes into little-endian 32-bit words and writes them into BRAM port A (the IMEM port).
- Holds the core in reset from start of load until the last word is committed, then releases it.

Parameters:
- MEM_BYTES, 4096: IMEM capacity in bytes; larger payload lengths are rejected.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between accepted bytes while loading.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored otherwise.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts byte this cycle.
- mem_we  output  4  BRAM port A byte write enables.
- mem_addr  output  32  BRAM port A byte address, word aligned.
- mem_di  output  32  BRAM port A write data.
- core_rst_n  output  1  active-low reset to pipeline.
- busy  output  1  high in LEN/DATA/FLUSH.
- done  output  1  high in DONE.
- err  output  1  high in ERR.

Behaviour:
- Reset (async) values:
  - All outputs 0, so core_rst_n=0 and the core is held after power-up.
  - State IDLE; all counters and the accumulator 0.
- States:
  - IDLE -start-> LEN.
  - LEN: accept 4 header bytes, little-endian, giving byte count N.
  - DATA: accept N payload bytes.
  - FLUSH: one cycle for the final write.
  - DONE, ERR: terminal until start.
- Handshake:
  - A byte transfers on rx_valid && rx_ready.
  - rx_ready=1 combinationally in LEN and DATA, else 0.
  - At most one byte per cycle.
- Header checks, evaluated on the 4th header byte:
  - N==0 or N>MEM_BYTES -> ERR next cycle, with no memory writes.
  - Otherwise -> DATA, with word address 0, byte lane 0 and remaining count N.
- Packing:
  - Byte k of a word goes to bits [8k+7:8k].
  - On the 4th byte of a word, the next cycle drives:
    - mem_we=4'hF;
    - mem_addr=word_index*4;
    - mem_di=the assembled word.
  - This is a single-cycle pulse; at all other times mem_we=0.
  - Byte collection continues in parallel, so back-to-back bytes never stall.
- Tail handling:
  - When remaining reaches 0 on a complete word, that write happens in the FLUSH cycle.
  - When remaining reaches 0 on a partial word, unfilled upper lanes are zero, mem_we=4'hF, and the write happens in FLUSH.
- Release timing:
  - DONE is entered the cycle after FLUSH.
  - core_rst_n is registered: 1 only in DONE, 0 in every other state.
  - The first core fetch therefore sees fully written memory.
- Timeout:
  - An idle counter runs in LEN/DATA and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - A pending partial word is discarded (no write); words already written stay written.
- Restart:
  - start in DONE or ERR -> LEN.
  - core_rst_n drops to 0 the next cycle; counters and the accumulator clear.
- Simultaneous events:
  - start during LEN/DATA/FLUSH is ignored.
  - An rx byte in the same cycle as a timeout expiry is accepted and the timeout is cancelled.
- rst_n asserted mid-load: immediate return to reset values; partial data in memory is undefined to the core, which stays in reset.
- Arithmetic: word_index is 30 bits; remaining is 32 bits unsigned; the idle counter is sized $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Shared package (alongside the existing core constants):
  - loader state encoding (IDLE=0, LEN, DATA, FLUSH, DONE, ERR);
  - HDR_BYTES=4;
  - default MEM_BYTES.
- Natural sub-module: byte_packer.
  - Accumulates bytes into lanes.
  - Produces word_valid, word and tail flush with zero fill.
  - Carries a clear input.
  - The FSM, counters and timeout stay in imem_loader.

Test Plan:
1. start; stream 08 00 00 00 13 00 00 00 93 00 10 00 -> two writes: addr 0/di 0x00000013/we F, then addr 4/di 0x00100093/we F; done=1 and core_rst_n=1 one cycle after the last write.
2. Header N=5, payload 01 02 03 04 AB -> writes 0x04030201@0, then 0x000000AB@4 in FLUSH; done=1.
3. Header 00 00 00 00 -> err=1 the cycle after the 4th byte; mem_we never set; core_rst_n stays 0.
4. Header N=4097 (01 10 00 00) with MEM_BYTES=4096 -> err=1; no writes. Then start and a valid 4-byte load -> done=1.
5. TIMEOUT_CYCLES=16; N=8; send 3 payload bytes then idle -> err=1 after 16 idle cycles; no write at addr 0. The same case with a byte arriving on cycle 16 -> no error.
6. rst_n pulsed low mid-DATA -> outputs 0 asynchronously; start pulses during DATA are ignored; after reset a full 8-byte load completes correctly.
